// File: rtl/tmr_mon_pkg.sv
// tmr_mon_pkg: shared lane state, lane number type and default parameters for the TMR monitor
package tmr_mon_pkg;
  typedef enum logic [1:0] {OK, SUSPECT, FAILED} lane_state_t;
  typedef logic [1:0] lane_num_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_FAIL_THRESH = 3;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/tmr_lane_tracker.sv
// tmr_lane_tracker: per-lane health FSM with consecutive-miss and saturating total-error counters
module tmr_lane_tracker
  import tmr_mon_pkg::*;
#(
  parameter int FAIL_THRESH = DEF_FAIL_THRESH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  logic             mismatch,
  output logic             failed,
  output logic             enter_failed,
  output logic [CNT_W-1:0] total
);
  lane_state_t state, state_nx;
  logic [3:0] consec, consec_nx;
  always_comb begin
    state_nx = state;
    consec_nx = consec;
    if (sample) begin
      case (state)
        OK: if (mismatch) begin
          consec_nx = 4'd1;
          state_nx = (FAIL_THRESH == 1) ? FAILED : SUSPECT;
        end
        SUSPECT: begin
          consec_nx = mismatch ? consec + 4'd1 : 4'd0;
          state_nx = !mismatch ? OK : (consec_nx == 4'(FAIL_THRESH)) ? FAILED : SUSPECT;
        end
        default: ;
      endcase
    end
  end
  assign failed = (state == FAILED);
  assign enter_failed = (state != FAILED) && (state_nx == FAILED);
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state <= OK;
      consec <= 4'd0;
      total <= '0;
    end else begin
      state <= state_nx;
      consec <= consec_nx;
      if (sample && mismatch && total != '1) total <= total + CNT_W'(1);
    end
  end
endmodule

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: watches three TMR replicas against the voter output and reports failed lanes
module tmr_fault_monitor
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FAIL_THRESH = DEF_FAIL_THRESH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] data_3,
  input  logic [WIDTH-1:0] tmr_out,
  input  logic             clear,
  output logic [2:0]       lane_failed,
  output logic             multi_fault,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output lane_num_t        rpt_lane,
  output logic [CNT_W-1:0] rpt_count
);
  logic [WIDTH-1:0] data [3];
  logic [CNT_W-1:0] totals [3];
  logic [2:0] mis, enter, pending, load_mask;
  logic [1:0] sel;
  logic take, multi;
  assign data[0] = data_1;
  assign data[1] = data_2;
  assign data[2] = data_3;
  for (genvar g = 0; g < 3; g++) begin : g_lane
    assign mis[g] = in_valid && (data[g] != tmr_out);
    tmr_lane_tracker #(.FAIL_THRESH(FAIL_THRESH), .CNT_W(CNT_W)) u_lane (
      .clk(clk), .rst_n(rst_n), .clear(clear), .sample(in_valid), .mismatch(mis[g]),
      .failed(lane_failed[g]), .enter_failed(enter[g]), .total(totals[g])
    );
  end
  assign multi = (mis[0] & mis[1]) | (mis[0] & mis[2]) | (mis[1] & mis[2]);
  // Lowest-numbered pending lane wins; the slot refills on the same edge a report is accepted.
  assign take = (!rpt_valid || rpt_ready) && |pending;
  assign sel = pending[0] ? 2'd0 : pending[1] ? 2'd1 : 2'd2;
  assign load_mask = take ? (3'b001 << sel) : 3'b000;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pending <= 3'b000;
      multi_fault <= 1'b0;
      rpt_valid <= 1'b0;
      rpt_lane <= '0;
      rpt_count <= '0;
    end else begin
      pending <= (pending & ~load_mask) | enter;
      if (multi) multi_fault <= 1'b1;
      if (!rpt_valid || rpt_ready) rpt_valid <= |pending;
      if (take) begin
        rpt_lane <= sel + 2'd1;
        rpt_count <= totals[sel];
      end
    end
  end
endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb_tmr_fault_monitor: table-driven and directed checks of the TMR fault monitor
module tb_tmr_fault_monitor;
  logic clk = 0, rst_n = 0, in_valid = 0, clear = 0, rpt_ready = 0;
  logic [3:0] data_1 = 0, data_2 = 0, data_3 = 0, tmr_out = 0;
  logic [2:0] lane_failed;
  logic multi_fault, rpt_valid;
  logic [1:0] rpt_lane;
  logic [7:0] rpt_count;
  int checks = 0, errors = 0;

  tmr_fault_monitor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_1(data_1), .data_2(data_2),
    .data_3(data_3), .tmr_out(tmr_out), .clear(clear), .lane_failed(lane_failed),
    .multi_fault(multi_fault), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_lane(rpt_lane), .rpt_count(rpt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, clear, valid;
    logic [3:0] d1, d2, d3, t;
    logic ready;
    logic [2:0] lf;
    logic mf, rv;
    logic [1:0] rl;
    logic [7:0] rc;
  } vec_t;

  vec_t v [24];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rn, input logic cl, input logic vl, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] c, input logic [3:0] t, input logic rd);
    rst_n = rn; clear = cl; in_valid = vl;
    data_1 = a; data_2 = b; data_3 = c; tmr_out = t; rpt_ready = rd;
  endtask

  initial begin
    // rst_n clear valid d1 d2 d3 t ready | lane_failed multi rpt_valid rpt_lane rpt_count
    v[0]  = '{0,0,0,4'h0,4'h0,4'h0,4'h0,0, 3'b000,0,0,0,0};
    v[1]  = '{1,0,1,4'hB,4'hB,4'hF,4'hB,0, 3'b000,0,0,0,0};
    v[2]  = '{1,0,1,4'hB,4'hB,4'hF,4'hB,0, 3'b000,0,0,0,0};
    v[3]  = '{1,0,1,4'hB,4'hB,4'hF,4'hB,0, 3'b100,0,0,0,0};
    v[4]  = '{1,0,0,4'h0,4'h0,4'h0,4'h0,0, 3'b100,0,1,3,3};
    v[5]  = '{1,0,0,4'h0,4'h0,4'h0,4'h0,1, 3'b100,0,0,0,0};
    v[6]  = '{1,1,0,4'h0,4'h0,4'h0,4'h0,0, 3'b000,0,0,0,0};
    v[7]  = '{1,0,1,4'h3,4'h5,4'h6,4'h7,0, 3'b000,1,0,0,0};
    v[8]  = '{1,0,0,4'h0,4'h0,4'h0,4'h0,0, 3'b000,1,0,0,0};
    v[9]  = '{1,1,0,4'h0,4'h0,4'h0,4'h0,0, 3'b000,0,0,0,0};
    v[10] = '{1,0,1,4'hF,4'h9,4'h9,4'h9,0, 3'b000,0,0,0,0};
    v[11] = '{1,0,1,4'hF,4'h9,4'h9,4'h9,0, 3'b000,0,0,0,0};
    v[12] = '{1,0,1,4'h9,4'h9,4'h9,4'h9,0, 3'b000,0,0,0,0};
    v[13] = '{1,0,1,4'hF,4'h9,4'h9,4'h9,0, 3'b000,0,0,0,0};
    v[14] = '{1,0,1,4'hF,4'h9,4'h9,4'h9,0, 3'b000,0,0,0,0};
    v[15] = '{1,0,1,4'hF,4'h9,4'h9,4'h9,0, 3'b001,0,0,0,0};
    v[16] = '{1,0,0,4'h0,4'h0,4'h0,4'h0,0, 3'b001,0,1,1,5};
    v[17] = '{1,0,0,4'h0,4'h0,4'h0,4'h0,0, 3'b001,0,1,1,5};
    v[18] = '{1,1,1,4'hF,4'h9,4'h9,4'h9,1, 3'b000,0,0,0,0};
    v[19] = '{1,0,1,4'hF,4'h9,4'h9,4'h9,0, 3'b000,0,0,0,0};
    v[20] = '{1,0,1,4'hF,4'h9,4'h9,4'h9,0, 3'b000,0,0,0,0};
    v[21] = '{1,0,1,4'hF,4'h9,4'h9,4'h9,0, 3'b001,0,0,0,0};
    v[22] = '{1,0,0,4'h0,4'h0,4'h0,4'h0,0, 3'b001,0,1,1,3};
    v[23] = '{1,1,0,4'h0,4'h0,4'h0,4'h0,0, 3'b000,0,0,0,0};

    for (int i = 0; i < 24; i++) begin
      drive(v[i].rst_n, v[i].clear, v[i].valid, v[i].d1, v[i].d2, v[i].d3, v[i].t, v[i].ready);
      step();
      chk($sformatf("vec%0d lane_failed", i), lane_failed, v[i].lf);
      chk($sformatf("vec%0d multi_fault", i), multi_fault, v[i].mf);
      chk($sformatf("vec%0d rpt_valid", i), rpt_valid, v[i].rv);
      if (v[i].rv || !v[i].rst_n || v[i].clear) begin
        chk($sformatf("vec%0d rpt_lane", i), rpt_lane, v[i].rl);
        chk($sformatf("vec%0d rpt_count", i), rpt_count, v[i].rc);
      end
      if (i == 12) chk("lane1 total after recovery", dut.totals[0], 2);
      if (i == 18) chk("lane1 total after clear", dut.totals[0], 0);
    end

    // Lanes 1 and 3 fail together; reports come out in ascending order under backpressure.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 4'h0, 4'h5, 4'hF, 4'h5, 0);
      step();
    end
    chk("dual fail lane_failed", lane_failed, 3'b101);
    drive(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("held%0d rpt_valid", i), rpt_valid, 1);
      chk($sformatf("held%0d rpt_lane", i), rpt_lane, 1);
      chk($sformatf("held%0d rpt_count", i), rpt_count, 3);
    end
    rpt_ready = 1;
    step();
    chk("second rpt_valid", rpt_valid, 1);
    chk("second rpt_lane", rpt_lane, 3);
    chk("second rpt_count", rpt_count, 3);
    step();
    chk("drained rpt_valid", rpt_valid, 0);
    drive(1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    step();

    // Lane 2 mismatches 300 times: report carries 3, total saturates at 255.
    drive(1, 0, 1, 4'h0, 4'h1, 4'h0, 4'h0, 1);
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 2) chk("sat lane_failed", lane_failed, 3'b010);
      if (i == 3) begin
        chk("sat rpt_valid", rpt_valid, 1);
        chk("sat rpt_lane", rpt_lane, 2);
        chk("sat rpt_count", rpt_count, 3);
      end
      if (i == 4) chk("sat rpt consumed", rpt_valid, 0);
      if (i == 253) chk("lane2 total pre-sat", dut.totals[1], 254);
    end
    chk("lane2 total saturated", dut.totals[1], 255);
    chk("sat multi_fault", multi_fault, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
